// File: rtl/logeo_trigger_ring.sv
// Sample logger into dual-port RAM: one-shot fill (mode 0) or circular capture with
// a pre/post trigger split (mode 1). Reads use logical addresses, 0 = oldest sample.
module logeo_trigger_ring #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32000,
  parameter int ADDR_WIDTH  = 15,
  parameter int PRE_SAMPLES = 16000
) (
  input  logic                  clock,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_mode,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_trigger,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_dato,
  output logic                  o_busy,
  output logic                  o_trig_seen,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   PRE_C    = (ADDR_WIDTH+1)'(PRE_SAMPLES);
  localparam logic [ADDR_WIDTH:0]   POST_C   = (ADDR_WIDTH+1)'(DEPTH - PRE_SAMPLES);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam bit                    POST_ONE = (DEPTH - PRE_SAMPLES) == 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
  logic [ADDR_WIDTH:0]     count_reg;
  logic [ADDR_WIDTH:0]     post_left_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    trig_seen_reg;

  logic [DATA_WIDTH-1:0]   ram [0:DEPTH-1];
  logic [DATA_WIDTH-1:0]   ram_q_reg;
  logic                    rd_zero_reg;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   ptr_inc;
  logic [ADDR_WIDTH:0]     count_inc;
  logic [ADDR_WIDTH:0]     count_sat;
  logic [ADDR_WIDTH-1:0]   base;
  logic [ADDR_WIDTH:0]     rd_sum;
  logic [ADDR_WIDTH-1:0]   rd_phys;

  // Start/abort cycles never write: the capture restarts or stops before this sample.
  assign wr_en     = i_valid && !i_abort && !i_start &&
                     (state_reg == S_FILL || state_reg == S_ARMED || state_reg == S_POST);
  assign ptr_inc   = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
  assign count_inc = count_reg + 1'b1;
  assign count_sat = (count_reg == DEPTH_C) ? count_reg : count_inc;

  // Once frozen, the write pointer sits on the oldest sample in both modes.
  assign base    = (state_reg == S_DONE) ? wr_ptr_reg : '0;
  assign rd_sum  = {1'b0, base} + {1'b0, i_rd_addr};
  assign rd_phys = ADDR_WIDTH'((rd_sum >= DEPTH_C) ? rd_sum - DEPTH_C : rd_sum);

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      post_left_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      trig_seen_reg <= 1'b0;
    end else if (i_abort) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (i_start) begin
      state_reg     <= i_mode ? S_ARMED : S_FILL;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      post_left_reg <= '0;
      busy_reg      <= 1'b1;
      done_reg      <= 1'b0;
      trig_seen_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FILL: begin
          if (i_valid) begin
            wr_ptr_reg <= ptr_inc;
            count_reg  <= count_inc;
            if (count_inc == DEPTH_C) begin
              state_reg <= S_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (i_valid) begin
            wr_ptr_reg <= ptr_inc;
            count_reg  <= count_sat;
          end
          // A sample arriving with the trigger is already the first post-trigger sample.
          if (i_trigger && count_reg >= PRE_C) begin
            trig_seen_reg <= 1'b1;
            if (i_valid && POST_ONE) begin
              state_reg <= S_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg     <= S_POST;
              post_left_reg <= POST_C - (ADDR_WIDTH+1)'(i_valid);
            end
          end
        end
        S_POST: begin
          if (i_valid) begin
            wr_ptr_reg    <= ptr_inc;
            count_reg     <= count_sat;
            post_left_reg <= post_left_reg - 1'b1;
            if (post_left_reg == (ADDR_WIDTH+1)'(1)) begin
              state_reg <= S_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) ram[wr_ptr_reg] <= i_data;
  end

  always_ff @(posedge clock) begin
    if (i_rd_en) ram_q_reg <= ram[rd_phys];
  end

  // Reads past the stored count return zero; the flag also masks the RAM register at reset.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n)   rd_zero_reg <= 1'b1;
    else if (i_rd_en) rd_zero_reg <= ({1'b0, i_rd_addr} >= count_reg);
  end

  assign o_dato      = rd_zero_reg ? '0 : ram_q_reg;
  assign o_busy      = busy_reg;
  assign o_done      = done_reg;
  assign o_trig_seen = trig_seen_reg;
  assign o_count     = count_reg;

endmodule

// File: tb/tb_logeo_trigger_ring.sv
// Bench for logeo_trigger_ring: directed capture scenarios plus random traffic,
// checked every cycle against a sample-history reference model.
module tb_logeo_trigger_ring;

  localparam int DW  = 32;
  localparam int D   = 8;
  localparam int AW  = 3;
  localparam int PRE = 3;

  logic          clock = 1'b0;
  logic          i_reset_n;
  logic          i_start, i_abort, i_mode, i_valid, i_trigger, i_rd_en;
  logic [DW-1:0] i_data;
  logic [AW-1:0] i_rd_addr;
  logic [DW-1:0] o_dato;
  logic          o_busy, o_trig_seen, o_done;
  logic [AW:0]   o_count;

  always #5 clock = ~clock;

  logeo_trigger_ring #(
    .DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .PRE_SAMPLES(PRE)
  ) dut (
    .clock(clock), .i_reset_n(i_reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_mode(i_mode), .i_valid(i_valid), .i_data(i_data), .i_trigger(i_trigger),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_dato(o_dato), .o_busy(o_busy),
    .o_trig_seen(o_trig_seen), .o_done(o_done), .o_count(o_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: n = samples written since the last start, t = n when the
  // trigger was accepted (-1 if none), mem = RAM image indexed by write order mod D.
  logic [DW-1:0] mem [D];
  bit            active = 1'b0;
  bit            mode_m = 1'b0;
  int            n = 0;
  int            t = -1;
  logic [DW-1:0] exp_dato = '0;

  function automatic int m_count();
    return (n < D) ? n : D;
  endfunction

  function automatic bit m_done();
    if (!active) return 1'b0;
    if (mode_m)  return (t >= 0) && (n - t == D - PRE);
    return n == D;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, DW'(o_count), DW'(m_count()));
    check({tag, ".busy"},  DW'(o_busy), DW'(active && !m_done()));
    check({tag, ".done"},  DW'(o_done), DW'(m_done()));
    check({tag, ".trig"},  DW'(o_trig_seen), DW'(t >= 0));
    check({tag, ".dato"},  o_dato, exp_dato);
  endtask

  task automatic step(input bit st, input bit ab, input bit md, input bit vl,
                      input logic [DW-1:0] dt, input bit tr, input bit re,
                      input logic [AW-1:0] ra);
    int a;
    i_start = st; i_abort = ab; i_mode = md; i_valid = vl; i_data = dt;
    i_trigger = tr; i_rd_en = re; i_rd_addr = ra;
    @(posedge clock);
    a = int'(ra);
    if (re) begin
      if (a >= m_count())   exp_dato = '0;
      else if (m_done())    exp_dato = mem[(n + a) % D];
      else                  exp_dato = mem[a];
    end
    if (ab) active = 1'b0;
    else if (st) begin
      active = 1'b1; mode_m = md; n = 0; t = -1;
    end else if (active && !m_done()) begin
      if (tr && mode_m && t < 0 && m_count() >= PRE) t = n;
      if (vl) begin
        mem[n % D] = dt;
        n++;
      end
    end
    #1;
    check_all($sformatf("cyc st=%0d ab=%0d v=%0d tr=%0d rd=%0d@%0d", st, ab, vl, tr, re, ra));
  endtask

  task automatic sample(input logic [DW-1:0] dt, input bit tr);
    step(0, 0, 0, 1, dt, tr, 0, '0);
  endtask

  task automatic read_const(input int addr, input logic [DW-1:0] want);
    step(0, 0, 0, 0, '0, 0, 1, AW'(addr));
    check($sformatf("read_const@%0d", addr), o_dato, want);
  endtask

  int saved_count;

  initial begin
    i_reset_n = 1'b0;
    i_start = 0; i_abort = 0; i_mode = 0; i_valid = 0; i_data = '0;
    i_trigger = 0; i_rd_en = 0; i_rd_addr = '0;
    #12;
    check_all("reset");
    @(negedge clock);
    i_reset_n = 1'b1;

    // One-shot fill stops after DEPTH samples.
    step(1, 0, 0, 0, '0, 0, 0, '0);
    for (int i = 1; i <= 10; i++) sample(DW'(i), 0);
    check("fill.count8", DW'(o_count), DW'(8));
    for (int k = 0; k < D; k++) read_const(k, DW'(k + 1));

    // Circular capture, trigger with sample 12.
    step(1, 0, 1, 0, '0, 0, 0, '0);
    for (int i = 1; i <= 20; i++) sample(DW'(i), i == 12);
    for (int k = 0; k < D; k++) read_const(k, DW'(k + 9));

    // Early trigger ignored, trigger with sample 5 accepted.
    step(1, 0, 1, 0, '0, 0, 0, '0);
    for (int i = 1; i <= 12; i++) begin
      sample(DW'(i), i == 2 || i == 5);
      if (i == 2) check("early_trig_ignored", DW'(o_trig_seen), DW'(0));
    end
    for (int k = 0; k < D; k++) read_const(k, DW'(k + 2));

    // Abort beats start during POST.
    step(1, 0, 1, 0, '0, 0, 0, '0);
    for (int i = 1; i <= 5; i++) sample(DW'(100 + i), i == 4);
    saved_count = int'(o_count);
    step(1, 1, 0, 1, 32'hDEAD, 0, 0, '0);
    check("abort.done", DW'(o_done), DW'(0));
    check("abort.count", DW'(o_count), DW'(saved_count));

    // Read beyond count gives zero; disabled read holds.
    step(1, 0, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 3; i++) sample(32'hA0 + DW'(i), 0);
    read_const(1, 32'hA1);
    step(0, 0, 0, 0, '0, 0, 0, AW'(2));
    check("hold.nonzero", o_dato, 32'hA1);
    read_const(5, '0);
    step(0, 0, 0, 0, '0, 0, 0, AW'(1));
    check("hold.zero", o_dato, '0);

    // Asynchronous reset mid-fill.
    step(1, 0, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 4; i++) sample(32'hB0 + DW'(i), 0);
    read_const(2, 32'hB2);
    i_reset_n = 1'b0;
    #2;
    active = 1'b0; n = 0; t = -1; exp_dato = '0;
    check_all("async_reset");
    @(negedge clock);
    i_reset_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2, 1'($urandom),
           $urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 60, AW'($urandom_range(0, D - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
